// File: rtl/alu_serial_digit.sv
// ---------------------------------------------------------------------------
// alu_serial_digit
//
// Digit-serial ALU that processes DIGIT bits of two XLEN-bit operands per
// cycle, least-significant digit first. It sits between the serial
// register-file shifter and the writeback path.
//
// A one-cycle start pulse latches the opcode and consumes digit 0 in the same
// cycle. The remaining digits are consumed on consecutive cycles. Each result
// digit appears one cycle after its operands. done pulses together with the
// last result digit.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   start      one-cycle pulse; latches op and consumes digit 0
//   op         000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR,
//              101 PASS (rs1), 110 SLT, 111 SLTU
//   rs1_d      current rs1 digit
//   rs2_d      current rs2 digit
//   digit_idx  index of the digit expected this cycle (0 when idle)
//   busy       high while digits 1..NDIG-1 are being consumed
//   res_d      registered result digit
//   res_valid  res_d holds a valid digit
//   done       one-cycle pulse with the last res_valid
//   zero       whole result (or SLT/SLTU difference) was zero; held to next start
//   lt         SLT/SLTU compare result, 0 for other ops; held to next start
// ---------------------------------------------------------------------------
module alu_serial_digit #(
  parameter  int XLEN  = 32,
  parameter  int DIGIT = 1,
  localparam int NDIG  = XLEN / DIGIT,
  localparam int CW    = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [DIGIT-1:0] rs1_d,
  input  logic [DIGIT-1:0] rs2_d,
  output logic [CW-1:0]    digit_idx,
  output logic             busy,
  output logic [DIGIT-1:0] res_d,
  output logic             res_valid,
  output logic             done,
  output logic             zero,
  output logic             lt
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_PASS = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // A single-digit operation finishes in the cycle it is started.
  localparam logic SINGLE_DIGIT = (NDIG == 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NDIG - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [0:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [2:0]       op_r;
  logic             carry_r;
  logic [DIGIT-1:0] res_d_r;
  logic             res_valid_r;
  logic             done_r;
  logic             zacc_r;
  logic             zero_r;
  logic             lt_r;

  // ---------------------------------------------------------------------
  // Datapath signals
  // ---------------------------------------------------------------------
  logic             accept_s;
  logic             consume_s;
  logic             last_s;
  logic [2:0]       cur_op_s;
  logic             sub_s;
  logic             cmp_s;
  logic [DIGIT-1:0] b_s;
  logic             cin_s;
  logic [DIGIT:0]   sum_s;
  logic             cout_s;
  logic [DIGIT-1:0] res_s;
  logic             ovf_s;
  logic             lt_calc_s;
  logic             digit_nz_s;
  logic             zacc_next_s;

  // start is only honoured from IDLE; a start during RUN is ignored.
  assign accept_s  = (state_r == ST_IDLE) && start;
  assign consume_s = accept_s || (state_r == ST_RUN);

  // The digit being consumed now uses the fresh opcode on the start cycle,
  // and the latched one afterwards.
  assign cur_op_s  = accept_s ? op : op_r;

  // Last digit: either the start digit of a one-digit operand, or the
  // final count in RUN.
  assign last_s    = accept_s ? SINGLE_DIGIT : (cnt_r == LAST_IDX);

  // Opcode decode: subtract-style ops invert rs2 and inject a carry of 1.
  always_comb begin
    sub_s = 1'b0;
    cmp_s = 1'b0;
    case (cur_op_s)
      OP_SUB: begin
        sub_s = 1'b1;
        cmp_s = 1'b0;
      end
      OP_SLT, OP_SLTU: begin
        sub_s = 1'b1;
        cmp_s = 1'b1;
      end
      default: begin
        sub_s = 1'b0;
        cmp_s = 1'b0;
      end
    endcase
  end

  // Digit 0 always starts from the op's own carry-in, so a carry left over
  // from a previous operation can never leak into a new one.
  assign b_s    = sub_s ? ~rs2_d : rs2_d;
  assign cin_s  = accept_s ? sub_s : carry_r;
  assign sum_s  = {1'b0, rs1_d} + {1'b0, b_s} + {{DIGIT{1'b0}}, cin_s};
  assign cout_s = sum_s[DIGIT];

  // Result digit selection; compares stream zeros, writeback inserts lt.
  always_comb begin
    res_s = {DIGIT{1'b0}};
    case (cur_op_s)
      OP_ADD:  res_s = sum_s[DIGIT-1:0];
      OP_SUB:  res_s = sum_s[DIGIT-1:0];
      OP_XOR:  res_s = rs1_d ^ rs2_d;
      OP_AND:  res_s = rs1_d & rs2_d;
      OP_OR:   res_s = rs1_d | rs2_d;
      OP_PASS: res_s = rs1_d;
      OP_SLT:  res_s = {DIGIT{1'b0}};
      OP_SLTU: res_s = {DIGIT{1'b0}};
      default: res_s = {DIGIT{1'b0}};
    endcase
  end

  // Signed overflow of rs1 + ~rs2 + 1, judged on the most significant digit.
  assign ovf_s = (rs1_d[DIGIT-1] == b_s[DIGIT-1]) &&
                 (sum_s[DIGIT-1] != rs1_d[DIGIT-1]);

  // Compare result, only meaningful on the final digit.
  always_comb begin
    lt_calc_s = 1'b0;
    case (cur_op_s)
      OP_SLT:  lt_calc_s = sum_s[DIGIT-1] ^ ovf_s;
      OP_SLTU: lt_calc_s = ~cout_s;
      default: lt_calc_s = 1'b0;
    endcase
  end

  // Zero tracking looks at the difference for compares (rs1 == rs2) and at
  // the streamed result otherwise. The accumulator restarts on each start.
  assign digit_nz_s  = cmp_s ? (|sum_s[DIGIT-1:0]) : (|res_s);
  assign zacc_next_s = (accept_s ? 1'b0 : zacc_r) | digit_nz_s;

  // Sequencer: IDLE/RUN state, digit counter, latched opcode, digit carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      op_r    <= OP_ADD;
      carry_r <= 1'b0;
    end else begin
      if (accept_s) begin
        op_r <= op;
        if (SINGLE_DIGIT) begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
        end else begin
          state_r <= ST_RUN;
          cnt_r   <= CW'(1);
        end
      end else if (state_r == ST_RUN) begin
        op_r <= op_r;
        if (last_s) begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
        end else begin
          state_r <= ST_RUN;
          cnt_r   <= cnt_r + CW'(1);
        end
      end else begin
        op_r    <= op_r;
        state_r <= state_r;
        cnt_r   <= cnt_r;
      end

      if (consume_s) begin
        carry_r <= cout_s;
      end else begin
        carry_r <= carry_r;
      end
    end
  end

  // Output registers: result digit stream, done pulse, sticky zero/lt flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_d_r     <= {DIGIT{1'b0}};
      res_valid_r <= 1'b0;
      done_r      <= 1'b0;
      zacc_r      <= 1'b0;
      zero_r      <= 1'b0;
      lt_r        <= 1'b0;
    end else begin
      res_d_r     <= consume_s ? res_s : {DIGIT{1'b0}};
      res_valid_r <= consume_s;
      done_r      <= consume_s && last_s;

      if (consume_s) begin
        zacc_r <= zacc_next_s;
      end else begin
        zacc_r <= zacc_r;
      end

      // Flags are published with the last digit and cleared on a new start.
      if (consume_s && last_s) begin
        zero_r <= ~zacc_next_s;
        lt_r   <= lt_calc_s;
      end else if (accept_s) begin
        zero_r <= 1'b0;
        lt_r   <= 1'b0;
      end else begin
        zero_r <= zero_r;
        lt_r   <= lt_r;
      end
    end
  end

  assign digit_idx = cnt_r;
  assign busy      = (state_r == ST_RUN);
  assign res_d     = res_d_r;
  assign res_valid = res_valid_r;
  assign done      = done_r;
  assign zero      = zero_r;
  assign lt        = lt_r;

endmodule

// File: doc/alu_serial_digit.md
Name: alu_serial_digit

Overview:
- Digit-serial ALU. Generalises the existing 1-bit serial ALU to DIGIT bits per cycle over an XLEN-bit operand.
- Adds an internal digit sequencer, a start/busy/done handshake, signed and unsigned compare (SLT/SLTU), and a zero flag.
- Sits between the serial register-file shifter and the writeback path. Operands stream in LSB-digit first; results stream out LSB-digit first.

Parameters:
- XLEN, 32, operand width in bits.
- DIGIT, 1, bits processed per cycle. Legal values are 1, 2, 4, 8, 16, 32, and DIGIT must divide XLEN.
- Derived: NDIG = XLEN/DIGIT; CW = max(1, $clog2(NDIG)).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; latches op and consumes digit 0 in the same cycle
- op  in  3  000 ADD, 001 SUB, 010 XOR, 011 AND, 100 OR, 101 PASS (rs1, for shifts), 110 SLT, 111 SLTU
- rs1_d  in  DIGIT  current rs1 digit
- rs2_d  in  DIGIT  current rs2 digit
- digit_idx  out  CW  index of the digit expected this cycle; 0 in IDLE
- busy  out  1  high while in RUN
- res_d  out  DIGIT  registered result digit
- res_valid  out  1  res_d holds a valid digit
- done  out  1  one-cycle pulse, coincident with the last res_valid
- zero  out  1  result was all-zero; valid when done=1 and held until the next start
- lt  out  1  compare result for SLT/SLTU, 0 for other ops; valid when done=1 and held until the next start

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: res_d=0, res_valid=0, done=0, busy=0, zero=0, lt=0, digit_idx=0.
  - Internal: state=IDLE, carry=0, latched op=000.
  - Reset overrides any operation in progress; no done is produced for an aborted operation.
- FSM states: IDLE, RUN.
  - IDLE + start: latch op and process digit 0. If NDIG>1, go to RUN with cnt=1. If NDIG=1, stay in IDLE.
  - RUN: process digit cnt, then increment cnt. When cnt==NDIG-1, return to IDLE after processing that digit.
  - start while in RUN is ignored: op is not relatched and cnt is unaffected.
  - start in the cycle done is high is legal: the FSM is in IDLE then, so back-to-back operations run with zero bubble.
- Timing (cycle 0 = start cycle):
  - Digit k is consumed in cycle k.
  - res_d for digit k is valid in cycle k+1 with res_valid=1.
  - done=1 in cycle NDIG, so total latency is NDIG cycles.
  - res_valid=0 whenever no digit was processed in the previous cycle.
- Per-digit arithmetic:
  - Ripple carry across the DIGIT bits combinationally; the carry between digits is registered.
  - ADD: carry-in 0 at digit 0.
  - SUB/SLT/SLTU: b = ~rs2_d, carry-in 1 at digit 0.
  - The carry register is forced to its digit-0 value when start is accepted, so no stale carry survives from a previous op.
  - Logic ops and PASS ignore the carry.
- SLT/SLTU result stream:
  - res_d is driven as all zeros for every digit; the writeback unit inserts lt at bit 0.
  - SLTU: lt = ~carry_out of the final digit.
  - SLT: lt = diff_msb XOR overflow. Overflow is computed from the final digit as (a_msb == b_msb) && (diff_msb != a_msb), where b = ~rs2.
- zero flag:
  - Equals the NOR over all result digits. For SLT/SLTU it is taken over the internal difference, so zero=1 means rs1==rs2.
  - Cleared at start. It is an accumulate-OR register, inverted at output.
- Unconnected state: digit inputs are ignored when no digit is being consumed.

Test Plan:
- DIGIT=1: ADD 0xFFFFFFFF + 0x00000001 -> res_valid on cycles 1..32, reassembled result 0x00000000, zero=1, done=1 at cycle 32, busy high on cycles 1..31.
- DIGIT=4: SUB 5 - 7 -> 0xFFFFFFFE, done at cycle 8, zero=0; then ADD 3 + 4 started in the done cycle -> 0x00000007, done at cycle 16.
- DIGIT=8: SLT 0x80000000 vs 0x00000001 -> lt=1, res 0; SLTU with the same operands -> lt=0; SLT 7 vs 7 -> lt=0, zero=1.
- DIGIT=2: XOR 0xA5A5A5A5 ^ 0xFFFF0000 -> 0x5A5AA5A5; AND and OR of the same operands -> 0xA5A50000 and 0xFFFFA5A5; PASS -> 0xA5A5A5A5.
- DIGIT=4: ADD in progress, rst_n=0 at cycle 3 -> all outputs 0 next cycle, no done; a new ADD 1 + 1 started afterwards -> 0x00000002 (no stale carry).
- DIGIT=4: start pulsed with op=SUB at cycle 2 of an ADD 10 + 20 -> pulse ignored; result 0x0000001E, done at cycle 8; DIGIT=32 ADD 2 + 3 -> 5, done at cycle 1, busy never high.
